// File: rtl/uart_line_rx.sv
// UART receive front-end with a line parser: oversampled deframing, optional parity,
// and accumulation of decimal or hex digits up to a carriage return.
//
// state    | meaning
// S_IDLE   | line idle, waiting for a synchronised low
// S_START  | counting to start-bit mid point, glitch check
// S_DATA   | sampling 8 data bits, LSB first
// S_PARITY | sampling the parity bit (only when PARITY != 0)
// S_STOP   | sampling the stop bit, byte hand-off to the parser
module uart_line_rx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int MODE       = 0,
    parameter int MAX_DIGITS = 4,
    parameter int VALUE_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               RsRx,
    output logic [VALUE_W-1:0] value,
    output logic               value_valid,
    output logic               frame_err,
    output logic               parity_err,
    output logic               line_err,
    output logic               busy
);

    localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int SMP_W = $clog2(OVERSAMPLE);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
    localparam logic [SMP_W-1:0] SMP_FULL = SMP_W'(OVERSAMPLE - 1);
    localparam logic [SMP_W-1:0] SMP_HALF = SMP_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_DIGITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic [1:0]         sync_q;
    logic               rx_s;

    logic [DIV_W-1:0]   div_q;
    logic               tick;
    logic               restart;

    state_t             state_q, state_d;
    logic [SMP_W-1:0]   smp_q, smp_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shreg_q, shreg_d;
    logic               par_bad_q, par_bad_d;
    logic               busy_q, busy_d;
    logic               sample;
    logic               stop_sample;

    logic [VALUE_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               poison_q, poison_d;
    logic [VALUE_W-1:0] value_q, value_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               perr_q, perr_d;
    logic               lerr_q, lerr_d;

    logic               is_dig;
    logic [3:0]         dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], RsRx};
        end
    end

    assign rx_s = sync_q[1];

    // Down-counter re-phased on start detection so mid-bit samples track the frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= DIV_LOAD;
        end else if (restart || tick) begin
            div_q <= DIV_LOAD;
        end else begin
            div_q <= div_q - 1'b1;
        end
    end

    assign tick   = (div_q == '0);
    assign sample = tick && (smp_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            smp_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        smp_d       = smp_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        par_bad_d   = par_bad_q;
        busy_d      = busy_q;
        restart     = 1'b0;
        stop_sample = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d   = S_START;
                    busy_d    = 1'b1;
                    restart   = 1'b1;
                    smp_d     = SMP_HALF;
                    par_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (sample) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_DATA;
                        smp_d   = SMP_FULL;
                        bit_d   = '0;
                    end
                end else if (tick) begin
                    smp_d = smp_q - 1'b1;
                end
            end
            S_DATA: begin
                if (sample) begin
                    shreg_d = {rx_s, shreg_q[7:1]};
                    smp_d   = SMP_FULL;
                    if (bit_q == 3'd7) begin
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else if (tick) begin
                    smp_d = smp_q - 1'b1;
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_bad_d = ((^shreg_q) ^ rx_s) != (PARITY == 1);
                    smp_d     = SMP_FULL;
                    state_d   = S_STOP;
                end else if (tick) begin
                    smp_d = smp_q - 1'b1;
                end
            end
            S_STOP: begin
                if (sample) begin
                    stop_sample = 1'b1;
                    state_d     = S_IDLE;
                    busy_d      = 1'b0;
                end else if (tick) begin
                    smp_d = smp_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        is_dig = 1'b0;
        dig    = 4'd0;
        if (shreg_q >= 8'h30 && shreg_q <= 8'h39) begin
            is_dig = 1'b1;
            dig    = shreg_q[3:0];
        end else if (MODE == 1 && ((shreg_q >= 8'h41 && shreg_q <= 8'h46) ||
                                   (shreg_q >= 8'h61 && shreg_q <= 8'h66))) begin
            is_dig = 1'b1;
            dig    = shreg_q[3:0] + 4'd9;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            cnt_q    <= '0;
            poison_q <= 1'b0;
            value_q  <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            perr_q   <= 1'b0;
            lerr_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            poison_q <= poison_d;
            value_q  <= value_d;
            valid_q  <= valid_d;
            ferr_q   <= ferr_d;
            perr_q   <= perr_d;
            lerr_q   <= lerr_d;
        end
    end

    // Parity failure takes precedence; either error discards the byte and poisons the line.
    always_comb begin
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        poison_d = poison_q;
        value_d  = value_q;
        valid_d  = 1'b0;
        lerr_d   = 1'b0;
        ferr_d   = stop_sample && !par_bad_q && !rx_s;
        perr_d   = stop_sample && par_bad_q;

        if (stop_sample) begin
            if (par_bad_q || !rx_s) begin
                poison_d = 1'b1;
            end else if (is_dig) begin
                if (cnt_q < CNT_MAX) begin
                    if (MODE == 1) begin
                        acc_d = (acc_q << 4) | VALUE_W'(dig);
                    end else begin
                        acc_d = (acc_q << 3) + (acc_q << 1) + VALUE_W'(dig);
                    end
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    poison_d = 1'b1;
                end
            end else if (shreg_q == 8'h0D) begin
                if (poison_q) begin
                    lerr_d = 1'b1;
                end else if (cnt_q != '0) begin
                    value_d = acc_q;
                    valid_d = 1'b1;
                end
                acc_d    = '0;
                cnt_d    = '0;
                poison_d = 1'b0;
            end else if (shreg_q != 8'h0A) begin
                poison_d = 1'b1;
            end
        end
    end

    assign value       = value_q;
    assign value_valid = valid_q;
    assign frame_err   = ferr_q;
    assign parity_err  = perr_q;
    assign line_err    = lerr_q;
    assign busy        = busy_q;

endmodule
